// File: rtl/cossim_job_sequencer.sv
// ----------------------------------------------------------------------------
// cossim_job_sequencer
//   Host-side initiator for the microcoded cosine-similarity engine. Vector-pair
//   jobs arrive on a valid/ready stream into a small FIFO. They are issued to
//   the engine one at a time. Each result is captured and returned on a
//   valid/ready result stream. A per-job watchdog substitutes 16'hFFFF (flagged
//   by res_timeout) if the engine never completes.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   job stream handshake (in_ready = FIFO not full)
//   in_a_vec/in_b_vec   four packed 8-bit elements each, byte 0 = element 0
//   eng_start           engine start, high START_CYCLES cycles per job
//   eng_a_vec/eng_b_vec vectors presented to the engine, stable for the job
//   eng_done            engine done level
//   eng_result          engine cosine_similarity
//   res_valid/res_ready result stream handshake
//   res_data            result value (16'hFFFF on watchdog expiry)
//   res_timeout         result was produced by the watchdog
//   busy                sequencer not idle
//   jobs_done           completed jobs including timeouts, wraps
// ----------------------------------------------------------------------------
module cossim_job_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int START_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a_vec,
    input  logic [31:0] in_b_vec,
    output logic        eng_start,
    output logic [31:0] eng_a_vec,
    output logic [31:0] eng_b_vec,
    input  logic        eng_done,
    input  logic [15:0] eng_result,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        res_timeout,
    output logic        busy,
    output logic [15:0] jobs_done
);

    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam int SCW = $clog2(START_CYCLES + 1);
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CW-1:0]  FIFO_FULL = CW'(FIFO_DEPTH);
    localparam logic [SCW-1:0] SC_LAST   = SCW'(START_CYCLES - 1);
    localparam logic [WDW-1:0] WD_LAST   = WDW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_START  = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESULT = 2'd3;

    logic [31:0]    r_fifo_a [FIFO_DEPTH];
    logic [31:0]    r_fifo_b [FIFO_DEPTH];
    logic [PW-1:0]  r_wptr;
    logic [PW-1:0]  r_rptr;
    logic [CW-1:0]  r_count;

    logic [1:0]     r_state;
    logic [SCW-1:0] r_start_cnt;
    logic [WDW-1:0] r_wd;
    logic           r_done_q;
    logic [31:0]    r_eng_a;
    logic [31:0]    r_eng_b;
    logic [15:0]    r_res_data;
    logic           r_res_timeout;
    logic [15:0]    r_jobs_done;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_done_rise;

    // No pop-bypass: a full FIFO refuses a push even if a pop happens this cycle.
    assign w_full      = (r_count == FIFO_FULL);
    assign w_empty     = (r_count == '0);
    assign w_push      = in_valid && !w_full;
    assign w_pop       = (r_state == S_IDLE) && !w_empty;
    // Edge detection so a done level left high by the previous job is ignored.
    assign w_done_rise = eng_done && !r_done_q;

    assign in_ready    = !w_full;
    assign eng_start   = (r_state == S_START);
    assign res_valid   = (r_state == S_RESULT);
    assign busy        = (r_state != S_IDLE);
    assign eng_a_vec   = r_eng_a;
    assign eng_b_vec   = r_eng_b;
    assign res_data    = r_res_data;
    assign res_timeout = r_res_timeout;
    assign jobs_done   = r_jobs_done;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_a[r_wptr] <= in_a_vec;
            r_fifo_b[r_wptr] <= in_b_vec;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_start_cnt   <= '0;
            r_wd          <= '0;
            r_done_q      <= 1'b0;
            r_eng_a       <= '0;
            r_eng_b       <= '0;
            r_res_data    <= '0;
            r_res_timeout <= 1'b0;
            r_jobs_done   <= '0;
        end else begin
            r_done_q <= eng_done;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_eng_a     <= r_fifo_a[r_rptr];
                        r_eng_b     <= r_fifo_b[r_rptr];
                        r_start_cnt <= '0;
                        r_state     <= S_START;
                    end
                end
                S_START: begin
                    if (r_start_cnt == SC_LAST) begin
                        r_wd    <= '0;
                        r_state <= S_WAIT;
                    end else begin
                        r_start_cnt <= r_start_cnt + SCW'(1);
                    end
                end
                S_WAIT: begin
                    r_wd <= r_wd + WDW'(1);
                    // A completion seen in the final watchdog cycle still wins.
                    if (w_done_rise) begin
                        r_res_data    <= eng_result;
                        r_res_timeout <= 1'b0;
                        r_state       <= S_RESULT;
                    end else if (r_wd == WD_LAST) begin
                        r_res_data    <= 16'hFFFF;
                        r_res_timeout <= 1'b1;
                        r_state       <= S_RESULT;
                    end
                end
                S_RESULT: begin
                    if (res_ready) begin
                        r_jobs_done <= r_jobs_done + 16'd1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cossim_job_sequencer.sv
// ----------------------------------------------------------------------------
// tb_cossim_job_sequencer
//   Self-checking bench for cossim_job_sequencer. A behavioural engine answers
//   each job with the byte-wise dot product of A and B after a chosen delay, or
//   hangs. Expected results, issue order and latencies are derived per job from
//   the sequencer's documented rules; FIFO occupancy is tracked as accepted
//   minus issued jobs.
// ----------------------------------------------------------------------------
module tb_cossim_job_sequencer;

    localparam int DEPTH = 4;
    localparam int SC    = 2;
    localparam int TO    = 64;

    localparam int K_NORMAL = 0;
    localparam int K_HANG   = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a_vec;
    logic [31:0] in_b_vec;
    logic        eng_start;
    logic [31:0] eng_a_vec;
    logic [31:0] eng_b_vec;
    logic        eng_done;
    logic [15:0] eng_result;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_timeout;
    logic        busy;
    logic [15:0] jobs_done;

    always #5 clk = ~clk;

    cossim_job_sequencer #(
        .FIFO_DEPTH    (DEPTH),
        .START_CYCLES  (SC),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a_vec   (in_a_vec),
        .in_b_vec   (in_b_vec),
        .eng_start  (eng_start),
        .eng_a_vec  (eng_a_vec),
        .eng_b_vec  (eng_b_vec),
        .eng_done   (eng_done),
        .eng_result (eng_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_timeout(res_timeout),
        .busy       (busy),
        .jobs_done  (jobs_done)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          kind;
        int          delay;   // cycles from first eng_start cycle to done rise
        bit          keep;    // engine leaves a stale done level high
        logic [15:0] result;
    } job_t;

    int          n_checks = 0;
    int          n_errors = 0;

    job_t        jobq[$];
    job_t        offer;
    job_t        cur;
    bit          cur_active = 0;
    bit          accepted;
    bit          rand_rr = 0;
    int          cyc = 0;
    int          s_cycle;
    int          exp_rv_cycle;
    logic [15:0] exp_data;
    bit          exp_to;
    int          occ = 0;
    logic [15:0] jobs_model = '0;
    int          start_len = 0;
    bit          prev_start = 0;
    bit          prev_rv = 0;
    bit          hs_prev = 0;
    bit          idle_pending_prev = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] dot(input logic [31:0] a, input logic [31:0] b);
        int s = 0;
        for (int i = 0; i < 4; i++) s += int'(a[8*i +: 8]) * int'(b[8*i +: 8]);
        return s[15:0];
    endfunction

    // Samples one clock cycle at the falling edge, then advances to just after
    // the next rising edge and drives the engine model for the new cycle.
    task automatic tick();
        bit rose;
        bit hs;
        int occ_pre;
        int age;
        @(negedge clk);
        rose = eng_start && !prev_start;
        if (rose) begin
            chk("issue_overlap", cur_active, 0);
            chk("issue_nonempty", jobq.size() != 0, 1);
            if (jobq.size() != 0) begin
                cur = jobq.pop_front();
                occ--;
                chk("eng_a", eng_a_vec, cur.a);
                chk("eng_b", eng_b_vec, cur.b);
                cur_active = 1;
                s_cycle    = cyc;
                if (cur.kind == K_NORMAL && cur.delay >= SC && cur.delay <= SC + TO - 1) begin
                    exp_data     = cur.result;
                    exp_to       = 0;
                    exp_rv_cycle = s_cycle + cur.delay + 1;
                end else begin
                    exp_data     = 16'hFFFF;
                    exp_to       = 1;
                    exp_rv_cycle = s_cycle + SC + TO;
                end
            end
        end
        if (idle_pending_prev) chk("pop_latency", eng_start, 1);
        if (eng_start) start_len++;
        else if (prev_start) begin
            chk("start_len", start_len, SC);
            start_len = 0;
        end
        chk("in_ready", in_ready, occ < DEPTH);
        if (cur_active) begin
            chk("eng_a_stable", eng_a_vec, cur.a);
            chk("eng_b_stable", eng_b_vec, cur.b);
        end
        if (res_valid && !prev_rv) begin
            chk("rv_owner", cur_active, 1);
            chk("rv_latency", cyc, exp_rv_cycle);
        end
        if (res_valid) begin
            chk("res_data", res_data, exp_data);
            chk("res_timeout", res_timeout, exp_to);
            chk("start_in_result", eng_start, 0);
            chk("busy_in_result", busy, 1);
        end
        if (hs_prev) begin
            chk("rv_drop", res_valid, 0);
            chk("jobs_done", jobs_done, jobs_model);
        end
        hs = res_valid && res_ready;
        if (hs) begin
            jobs_model = jobs_model + 16'd1;
            cur_active = 0;
        end
        occ_pre = occ;
        if (in_valid && in_ready) begin
            jobq.push_back(offer);
            occ++;
            accepted = 1;
        end
        idle_pending_prev = !busy && occ_pre > 0;
        prev_start = eng_start;
        prev_rv    = res_valid;
        hs_prev    = hs;
        cyc++;
        @(posedge clk);
        #1;
        if (rand_rr) res_ready = ($urandom_range(0, 2) != 0);
        if (cur_active) begin
            age = cyc - s_cycle;
            if (cur.kind == K_NORMAL) begin
                if (age == cur.delay) begin
                    eng_done   = 1'b1;
                    eng_result = cur.result;
                end else if (age < cur.delay && (!cur.keep || age == cur.delay - 1)) begin
                    eng_done = 1'b0;
                end
            end else if (!cur.keep) begin
                eng_done = 1'b0;
            end
        end
        if (!eng_done) eng_result = 16'($urandom);
    endtask

    task automatic push_job(input logic [31:0] a, input logic [31:0] b,
                            input int kind, input int delay, input bit keep);
        offer.a      = a;
        offer.b      = b;
        offer.kind   = kind;
        offer.delay  = delay;
        offer.keep   = keep;
        offer.result = dot(a, b);
        in_a_vec = a;
        in_b_vec = b;
        in_valid = 1'b1;
        accepted = 0;
        for (int i = 0; i < 3000 && !accepted; i++) tick();
        chk("push_accepted", accepted, 1);
        in_valid = 1'b0;
        in_a_vec = $urandom;
        in_b_vec = $urandom;
    endtask

    task automatic drain();
        for (int i = 0; i < 5000; i++) begin
            if (jobq.size() == 0 && !cur_active) break;
            tick();
        end
        chk("drain_done", (jobq.size() == 0 && !cur_active), 1);
        tick();
        tick();
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        eng_done = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_eng_start", eng_start, 0);
        chk("rst_eng_a", eng_a_vec, 0);
        chk("rst_eng_b", eng_b_vec, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_timeout", res_timeout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_jobs_done", jobs_done, 0);
        jobq.delete();
        occ               = 0;
        cur_active        = 0;
        jobs_model        = '0;
        start_len         = 0;
        prev_start        = 0;
        prev_rv           = 0;
        hs_prev           = 0;
        idle_pending_prev = 0;
        cyc++;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_a_vec   = '0;
        in_b_vec   = '0;
        eng_done   = 1'b0;
        eng_result = '0;
        res_ready  = 1'b1;
        do_reset();

        // Single job, dot product 70 after 20 cycles.
        push_job(32'h04030201, 32'h08070605, K_NORMAL, 20, 0);
        drain();

        // Six jobs against a slow engine: FIFO fills, later pushes wait for pops.
        for (int j = 0; j < 6; j++) push_job($urandom, $urandom, K_NORMAL, 40, 0);
        drain();

        // Hung engine, then a normal job.
        push_job($urandom, $urandom, K_HANG, 0, 0);
        push_job($urandom, $urandom, K_NORMAL, 12, 0);
        drain();

        // Consumer back-pressure with another job waiting.
        res_ready = 1'b0;
        push_job($urandom, $urandom, K_NORMAL, 10, 0);
        for (int i = 0; i < 300 && !prev_rv; i++) tick();
        chk("bp_rv_seen", prev_rv, 1);
        push_job($urandom, $urandom, K_NORMAL, 8, 0);
        for (int i = 0; i < 9; i++) tick();
        res_ready = 1'b1;
        drain();

        // Stale done level carried across jobs.
        push_job($urandom, $urandom, K_NORMAL, 10, 0);
        push_job($urandom, $urandom, K_HANG, 0, 1);
        push_job($urandom, $urandom, K_NORMAL, 15, 1);
        drain();

        // Watchdog boundaries: done in last window cycle, one late, and in START.
        push_job($urandom, $urandom, K_NORMAL, SC + TO - 1, 0);
        push_job($urandom, $urandom, K_NORMAL, SC + TO, 0);
        push_job($urandom, $urandom, K_NORMAL, 1, 0);
        push_job($urandom, $urandom, K_NORMAL, SC, 0);
        drain();

        // Randomized traffic.
        rand_rr = 1;
        for (int j = 0; j < 40; j++) begin
            int r;
            int d;
            r = $urandom_range(0, 9);
            d = (r == 9) ? $urandom_range(1, SC + TO + 2) : $urandom_range(SC, 30);
            push_job($urandom, $urandom, (r == 0) ? K_HANG : K_NORMAL, d,
                     ($urandom_range(0, 3) == 0));
            for (int g = $urandom_range(0, 6); g > 0; g--) tick();
        end
        drain();
        rand_rr   = 0;
        res_ready = 1'b1;

        // Reset while waiting with two jobs queued.
        for (int j = 0; j < 3; j++) push_job($urandom, $urandom, K_NORMAL, 50, 0);
        for (int i = 0; i < 200 && !(cur_active && cyc - s_cycle > SC + 3); i++) tick();
        chk("rst_mid_wait_reached", cur_active && jobq.size() == 2, 1);
        do_reset();
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("post_rst_idle", busy, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cossim_job_sequencer.md
Name: cossim_job_sequencer

Overview:
- Host-side initiator for the microcoded cosine-similarity engine (control_store); drives the engine's start/A_vec/B_vec inputs and consumes its done/cosine_similarity outputs.
- Accepts vector-pair jobs on a valid/ready stream into a small FIFO and issues them to the engine one at a time.
- Captures each result and returns it on a valid/ready result stream. Includes a per-job watchdog so a hung engine cannot stall the stream.

Parameters:
FIFO_DEPTH, 4, input job FIFO entries (power of 2, >=2)
START_CYCLES, 2, cycles eng_start is held high per job (>=1)
TIMEOUT_CYCLES, 1024, max cycles in WAIT before forced timeout result (>=2)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  job offered
in_ready  output  1  job FIFO not full
in_a_vec  input  32  four packed 8-bit A elements, byte 0 = element 0
in_b_vec  input  32  four packed 8-bit B elements
eng_start  output  1  engine start
eng_a_vec  output  32  A vector to engine
eng_b_vec  output  32  B vector to engine
eng_done  input  1  engine done (level)
eng_result  input  16  engine cosine_similarity
res_valid  output  1  result held
res_ready  input  1  result consumer ready
res_data  output  16  result value
res_timeout  output  1  result produced by watchdog, qualified by res_valid
busy  output  1  state != IDLE
jobs_done  output  16  completed jobs, including timeouts; wraps

Behaviour:
- Reset values: in_ready=1, eng_start=0, eng_a_vec=0, eng_b_vec=0, res_valid=0, res_data=0, res_timeout=0, busy=0, jobs_done=0. FIFO is emptied, done_q=0, FSM=IDLE.
- Reset mid-job: all of the above apply at the next edge. The engine sees eng_start drop and is expected to be reset by the same reset.
- FIFO:
  - push on in_valid && in_ready; in_ready = !full, with no pop-bypass when full.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- done_q is the registered eng_done. done_rise = eng_done && !done_q.
- FSM:
  - IDLE: if FIFO non-empty, pop head into eng_a_vec/eng_b_vec, go to START, and set the start counter to 0.
  - START: eng_start=1. Stay START_CYCLES cycles, then go to WAIT and clear the watchdog.
  - WAIT: eng_start=0; the watchdog increments each cycle.
    - If done_rise, latch res_data=eng_result and res_timeout=0, then go to RESULT.
    - Else if watchdog reaches TIMEOUT_CYCLES-1, set res_data=16'hFFFF and res_timeout=1, then go to RESULT.
    - If done_rise and timeout coincide, done_rise wins.
  - RESULT: res_valid=1. On res_ready, go to IDLE, res_valid=0 next cycle, and jobs_done+1.
- eng_a_vec/eng_b_vec stay stable from the IDLE->START edge until the next pop, so they are stable for the whole job.
- done_rise is ignored outside WAIT. This includes a done level left high from the prior job, which is why edge detection is used.
- res_data/res_timeout are held stable while res_valid && !res_ready.
- Latency:
  - A job pushed at edge N into an empty FIFO in IDLE pops at edge N+1; eng_start is high for cycles N+1 .. N+START_CYCLES.
  - res_valid rises one edge after the cycle in which done_rise is seen.
  - Back-to-back: the next pop occurs on the edge after the RESULT handshake, giving one IDLE cycle between jobs.
- Arithmetic: jobs_done wraps 16'hFFFF -> 0. The watchdog is wide enough for TIMEOUT_CYCLES.

Test Plan:
1. Reset, push A=32'h04030201, B=32'h08070605, hold res_ready=1, engine model raises done 20 cycles after start with result 16'd70 -> eng_start high exactly 2 cycles; eng_a/b match inputs; res_valid one cycle after done rise with res_data=70, res_timeout=0; jobs_done=1.
2. Push 5 jobs with FIFO_DEPTH=4 while the engine is busy -> in_ready drops after 4 buffered; the 5th is accepted after the first pop; all 5 results are returned in order.
3. Engine never asserts done -> after TIMEOUT_CYCLES in WAIT, res_data=16'hFFFF, res_timeout=1; the next job still runs normally.
4. Hold res_ready=0 for 10 cycles after res_valid -> res_data stable, no new eng_start, FSM stays RESULT; releasing res_ready gives one handshake and jobs_done increments once.
5. eng_done held high continuously from the prior job into the next job -> no false completion; the next job completes only on a fresh low->high.
6. Assert reset during WAIT with 2 jobs queued -> next cycle eng_start=0, res_valid=0, busy=0, in_ready=1, jobs_done=0, and no queued job is issued afterward.
